// File: rtl/sr_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sr_cmd_gen
//  Purpose  : Command front end for a set/reset flip-flop. It synchronizes
//             and debounces two raw request lines and turns each debounced
//             rising edge into a one-cycle s or r pulse. Simultaneous
//             requests are serialized so s and r are never high together.
//  Ports    : clk      - clock, rising edge
//             rst      - asynchronous reset, active low
//             set_in   - raw set request (asynchronous)
//             clr_in   - raw clear request (asynchronous)
//             s, r     - registered one-cycle set / reset pulses
//             set_lvl  - debounced level of set_in
//             clr_lvl  - debounced level of clr_in
//             pend     - a losing request is waiting to be issued
//  Revision : 1.0  initial release
// ============================================================================
module sr_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3,
    parameter bit SET_PRIO  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic set_lvl,
    output logic clr_lvl,
    output logic pend
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND_S = 2'd1,
        ST_PEND_R = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Channel 0 carries the set request, channel 1 the clear request.
    logic [1:0]       w_raw;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       lvl_q, lvl_d;
    logic [1:0]       lvl_dly_q, lvl_dly_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       w_req;

    state_t state_q, state_d;
    logic   s_q, s_d;
    logic   r_q, r_d;

    assign w_raw = {clr_in, set_in};

    // ------------------------------------------------------------------
    // Synchronizer, debouncer and rising-edge detect for both channels
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d   = w_raw;
        sync2_d   = sync1_q;
        lvl_dly_d = lvl_q;
        lvl_d     = lvl_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            // Any agreeing sample restarts the persistence count, so only
            // DB_CYCLES consecutive disagreeing samples move the level.
            if (sync2_q[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == C_CNT_LAST) begin
                lvl_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        w_req = lvl_q & ~lvl_dly_q;
    end

    // ------------------------------------------------------------------
    // Arbiter: the loser of a simultaneous request is issued next cycle.
    // Requests arriving while a deferred pulse is pending are dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_req[0] && w_req[1]) begin
                    if (SET_PRIO) begin
                        s_d     = 1'b1;
                        state_d = ST_PEND_R;
                    end else begin
                        r_d     = 1'b1;
                        state_d = ST_PEND_S;
                    end
                end else if (w_req[0]) begin
                    s_d = 1'b1;
                end else if (w_req[1]) begin
                    r_d = 1'b1;
                end
            end
            ST_PEND_S: begin
                s_d     = 1'b1;
                state_d = ST_IDLE;
            end
            ST_PEND_R: begin
                r_d     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            lvl_dly_q <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            state_q   <= ST_IDLE;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_dly_d;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
            state_q   <= state_d;
            s_q       <= s_d;
            r_q       <= r_d;
        end
    end

    assign s       = s_q;
    assign r       = r_q;
    assign set_lvl = lvl_q[0];
    assign clr_lvl = lvl_q[1];
    assign pend    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_cmd_gen
//  Purpose  : Self-checking bench for sr_cmd_gen. Two instances share the
//             inputs: one with set priority, one with clear priority.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sr_cmd_gen;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst, set_in, clr_in;
    logic s1, r1, sl1, cl1, p1;
    logic s0, r0, sl0, cl0, p0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_cmd_gen #(.DB_CYCLES(DB), .CNT_W(3), .SET_PRIO(1'b1)) dut (
        .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
        .s(s1), .r(r1), .set_lvl(sl1), .clr_lvl(cl1), .pend(p1)
    );

    sr_cmd_gen #(.DB_CYCLES(DB), .CNT_W(3), .SET_PRIO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
        .s(s0), .r(r0), .set_lvl(sl0), .clr_lvl(cl0), .pend(p0)
    );

    // ---------------- reference model (event level) ----------------
    bit m_sync1 [2];
    bit m_sync2 [2];
    bit m_lvl   [2];
    bit m_prev  [2];
    bit win     [2][DB];   // most recent synchronized samples, [0] newest
    int win_n   [2];
    int q_hi[$];           // pulses still to issue, set-priority instance (1=S, 2=R)
    int q_lo[$];           // same, clear-priority instance
    bit e_s [2];
    bit e_r [2];
    bit e_p [2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_sync1[c] = 0; m_sync2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0;
            win_n[c] = 0;
            e_s[c] = 0; e_r[c] = 0; e_p[c] = 0;
        end
        q_hi.delete();
        q_lo.delete();
    endfunction

    function automatic void arb(input int p, input bit rs, input bit rr);
        int q[$];
        int k;
        if (p == 1) q = q_hi; else q = q_lo;
        if (q.size() == 0) begin
            if (rs && rr) begin
                if (p == 1) begin q.push_back(1); q.push_back(2); end
                else        begin q.push_back(2); q.push_back(1); end
            end else if (rs) q.push_back(1);
            else if (rr)     q.push_back(2);
        end
        e_s[p] = 0; e_r[p] = 0;
        if (q.size() > 0) begin
            k = q.pop_front();
            e_s[p] = (k == 1);
            e_r[p] = (k == 2);
        end
        e_p[p] = (q.size() > 0);
        if (p == 1) q_hi = q; else q_lo = q;
    endfunction

    function automatic void model_step();
        bit rs, rr, flip;
        rs = m_lvl[0] & ~m_prev[0];
        rr = m_lvl[1] & ~m_prev[1];
        arb(1, rs, rr);
        arb(0, rs, rr);
        for (int c = 0; c < 2; c++) begin
            m_prev[c] = m_lvl[c];
            for (int j = DB - 1; j > 0; j--) win[c][j] = win[c][j-1];
            win[c][0] = m_sync2[c];
            if (win_n[c] < DB) win_n[c]++;
            // Level moves once the last DB samples all disagree with it.
            flip = (win_n[c] == DB);
            for (int j = 0; j < DB; j++) if (win[c][j] == m_lvl[c]) flip = 0;
            if (flip) m_lvl[c] = ~m_lvl[c];
        end
        m_sync2[0] = m_sync1[0]; m_sync2[1] = m_sync1[1];
        m_sync1[0] = set_in;     m_sync1[1] = clr_in;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0b expected %0b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("s",        s1,  e_s[1]);
        chk("r",        r1,  e_r[1]);
        chk("pend",     p1,  e_p[1]);
        chk("set_lvl",  sl1, m_lvl[0]);
        chk("clr_lvl",  cl1, m_lvl[1]);
        chk("s_p0",     s0,  e_s[0]);
        chk("r_p0",     r0,  e_r[0]);
        chk("pend_p0",  p0,  e_p[0]);
        chk("set_lvl0", sl0, m_lvl[0]);
        chk("clr_lvl0", cl0, m_lvl[1]);
        chk("excl",     s1 & r1, 1'b0);
        chk("excl0",    s0 & r0, 1'b0);
    endtask

    // One rising edge; inputs are changed 1 time unit after the previous edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset(); else model_step();
        #1;
        cmp_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit si, ci;
        bit s, r, p, sl, cl;
        bit s0, r0;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit si, input bit ci, input bit s, input bit r,
                                input bit p, input bit sl, input bit cl,
                                input bit s0v, input bit r0v);
        vec_t v;
        v.si = si; v.ci = ci; v.s = s; v.r = r; v.p = p;
        v.sl = sl; v.cl = cl; v.s0 = s0v; v.r0 = r0v;
        tbl.push_back(v);
    endfunction

    initial begin
        int n_pulse, s_at, rises, falls;
        bit prev_sl;

        // Release with set held: level after E5, single s after E6.
        for (int k = 0; k < 9; k++) add(1, 0, k == 6, 0, 0, k >= 5, 0, k == 6, 0);
        // Falling edge: level drops after E5, no pulse.
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 0, k < 5, 0, 0, 0);
        // Simultaneous rise: winner after E6 with pend, loser after E7.
        for (int k = 0; k < 9; k++) add(1, 1, k == 6, k == 7, k == 6, k >= 5, k >= 5, k == 7, k == 6);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 0, k < 5, k < 5, 0, 0);
        // Glitch of 3 cycles is rejected.
        for (int k = 0; k < 9; k++) add(k < 3, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset hold with both inputs high; outputs are 0 without a clock.
        rst = 1'b0; set_in = 1'b1; clr_in = 1'b1;
        model_reset();
        #1;
        chk("rst_async_s", s1, 1'b0);
        chk("rst_async_pend", p1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_hold_s", s1, 1'b0);
            chk("rst_hold_set_lvl", sl1, 1'b0);
        end

        rst = 1'b1;
        foreach (tbl[i]) begin
            set_in = tbl[i].si;
            clr_in = tbl[i].ci;
            tick();
            chk($sformatf("tbl%0d_s", i),    s1,  tbl[i].s);
            chk($sformatf("tbl%0d_r", i),    r1,  tbl[i].r);
            chk($sformatf("tbl%0d_pend", i), p1,  tbl[i].p);
            chk($sformatf("tbl%0d_slvl", i), sl1, tbl[i].sl);
            chk($sformatf("tbl%0d_clvl", i), cl1, tbl[i].cl);
            chk($sformatf("tbl%0d_s0", i),   s0,  tbl[i].s0);
            chk($sformatf("tbl%0d_r0", i),   r0,  tbl[i].r0);
        end
        chk_int("glitch_cnt", int'(dut.cnt_q[0]), 0);

        // Reset during the winner pulse discards the deferred request.
        set_in = 1'b1; clr_in = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("midpend_s_before", s1, 1'b1);
        chk("midpend_pend_before", p1, 1'b1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("midpend_s_now", s1, 1'b0);
        chk("midpend_pend_now", p1, 1'b0);
        chk("midpend_r_now", r1, 1'b0);
        chk("midpend_slvl_now", sl1, 1'b0);
        chk("midpend_pend0_now", p0, 1'b0);
        set_in = 1'b0; clr_in = 1'b0;
        tick(); tick();
        rst = 1'b1;
        n_pulse = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (s1 || r1 || s0 || r0) n_pulse++;
        end
        chk_int("midpend_no_late_pulse", n_pulse, 0);

        // Bounce: toggles for 10 cycles, then held high.
        n_pulse = 0; s_at = -1; rises = 0; falls = 0; prev_sl = sl1;
        for (int k = 0; k < 22; k++) begin
            set_in = (k < 10) ? (k % 2 == 0) : 1'b1;
            tick();
            if (s1) begin n_pulse++; s_at = k; end
            if (sl1 && !prev_sl) rises++;
            if (!sl1 && prev_sl) falls++;
            prev_sl = sl1;
        end
        chk_int("bounce_pulses", n_pulse, 1);
        chk_int("bounce_pulse_at", s_at, 16);
        chk_int("bounce_lvl_rises", rises, 1);
        chk_int("bounce_lvl_falls", falls, 0);
        set_in = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Random traffic with occasional resets, checked against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end else begin
                if ($urandom_range(0, 9) == 0) begin
                    set_in = 1'($urandom_range(0, 1));
                    clr_in = set_in;
                end else begin
                    if ($urandom_range(0, 4) == 0) set_in = ~set_in;
                    if ($urandom_range(0, 4) == 0) clr_in = ~clr_in;
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Upstream command stage for the `srff` set/reset flip-flop. It takes two raw, possibly bouncing and asynchronous request lines (`set_in`, `clr_in`), synchronizes and debounces them, and converts each debounced rising edge into a single-cycle `s` or `r` pulse. Simultaneous requests are arbitrated and serialized, so `s` and `r` are never high in the same cycle and the flip-flop never enters its undefined `s&r` state. Outputs drive the flip-flop's `s`/`r` inputs directly.

## Interface
- `DB_CYCLES`, default 4: consecutive synchronized cycles a new input value must persist before the debounced level changes. Legal values are ≥1.
- `CNT_W`, default 3: debounce counter width. Must satisfy 2^CNT_W ≥ DB_CYCLES.
- `SET_PRIO`, default 1: on simultaneous requests, 1 means `s` wins and 0 means `r` wins.
- `clk`  in  1  clock; all flops update on the rising edge.
- `rst`  in  1  reset; asynchronous and active-low (0 = reset).
- `set_in`  in  1  raw set request, asynchronous to `clk`.
- `clr_in`  in  1  raw clear request, asynchronous to `clk`.
- `s`  out  1  registered one-cycle set pulse.
- `r`  out  1  registered one-cycle reset pulse.
- `set_lvl`  out  1  debounced level of `set_in`.
- `clr_lvl`  out  1  debounced level of `clr_in`.
- `pend`  out  1  high while a deferred (losing) request is waiting to be issued.

## Operation
- **Per-channel pipeline:** a 2-flop synchronizer (`sync1` → `sync2`), then the debouncer, then the edge detector.
- **Debouncer:** on each edge, if `sync2 == lvl`, then `cnt <= 0`. Otherwise:
  - if `cnt == DB_CYCLES-1`: `lvl <= sync2` and `cnt <= 0`;
  - else: `cnt <= cnt+1`.
  - Any cycle where the synchronized value agrees with the level clears the count. A pulse shorter than DB_CYCLES synchronized cycles is discarded.
- **Edge detect:** `req = lvl & ~lvl_d`, where `lvl_d` is `lvl` delayed one cycle. It is combinational and internal. Falling edges produce no pulse.
- **Arbiter FSM states:** IDLE, PEND_S, PEND_R.
  - IDLE, only `req_s`: `s <= 1`; stay in IDLE.
  - IDLE, only `req_r`: `r <= 1`; stay in IDLE.
  - IDLE, both requests with SET_PRIO=1: `s <= 1`; go to PEND_R.
  - IDLE, both requests with SET_PRIO=0: `r <= 1`; go to PEND_S.
  - PEND_R: `r <= 1`, `s <= 0`; go to IDLE.
  - PEND_S: `s <= 1`, `r <= 0`; go to IDLE.
  - Any cycle not listed above drives `s <= 0` and `r <= 0`.
- **`pend`:** equals `state != IDLE`, decoded from state.
- **New requests during PEND:** they cannot occur by construction, because a channel needs a falling edge plus a rising edge (≥2 cycles) before it can re-request. If one does occur, it is dropped. The pending pulse is always issued.
- **Invariant:** `s & r == 0` in every cycle, including the reset-release cycle.
- **Reset:** asynchronous `rst=0` clears the following to 0, and the FSM goes to IDLE:
  - all synchronizer flops, `lvl`, `lvl_d`, `cnt`;
  - `s`, `r`, `pend`.
- **Reset effects:**
  - Reset mid-PEND discards the deferred request; no late pulse is issued.
  - Release is synchronous through the flops. An input already high at release produces exactly one pulse after the normal latency.

## Timing
- **Reference point:** the raw input changes and is stable before clock edge E0.
- **Synchronizer:** `sync1=1` after E0; `sync2=1` after E1.
- **Level:** `set_lvl`/`clr_lvl` change after edge E(DB_CYCLES+1). With DB_CYCLES=4, that is E5.
- **Pulse:** `s`/`r` goes high after E(DB_CYCLES+2) and low after E(DB_CYCLES+3). It is exactly one cycle wide.
- **Simultaneous requests:** the winner pulses in cycle E(DB+2)–E(DB+3) with `pend=1` in that same cycle. The loser pulses in the next cycle with `pend=0`.
- **Minimum spacing:** same-channel pulses are separated by ≥ 2·DB_CYCLES+… cycles, limited by the debounce.
- **Reset outputs:** `s`, `r`, `pend`, `set_lvl`, `clr_lvl` are all 0 immediately on `rst` falling, with no clock required.

## Test plan
- **Reset hold:** `rst=0` with `set_in=clr_in=1` for 5 cycles → all outputs 0. Release with `set_in` held 1, DB_CYCLES=4 → `set_lvl` rises after E5; `s=1` only in cycle after E6.
- **Glitch reject:** `set_in` high for 3 cycles then low (DB=4) → `set_lvl` stays 0, `s` never 1, `cnt` returns to 0.
- **Simultaneous, SET_PRIO=1:** `set_in` and `clr_in` rise before the same edge → `s` after E6 with `pend=1`, `r` after E7, `pend=0` after E7, never `s&r`. With SET_PRIO=0: `r` first, then `s`.
- **Falling edge:** `set_in` drops after a stable high → `set_lvl` falls DB+1 edges later; no `s`/`r` pulse.
- **Reset mid-PEND:** assert `rst=0` during the winner-pulse cycle → `pend` and `s` drop immediately; no `r` pulse after release with both inputs low.
- **Bounce:** toggle `set_in` every cycle for 10 cycles, then hold 1 → exactly one `s` pulse, DB+2 edges after the last toggle; `set_lvl` never oscillates.
